ldpc_hd_collect: RTL
====================

Name: ldpc_hd_collect

Overview:
- Consumer end of the (20,10) LDPC decoder's variable-node output stream.
- Captures indexed 3-bit soft values as the decoder writes them, slices each to a hard bit, then serially recomputes the 10-bit syndrome over the fixed parity-check matrix.
- Presents the decoded 20-bit word plus syndrome and an active-low ok_n to a downstream sink, using a valid/ready handshake.

Parameters:
- N, 20: codeword length (variable nodes); fixed for this code.
- M, 10: number of check nodes.
- W, 3: soft-value width; MSB is the hard decision.

Ports:
- clk  in  1  system clock; all state changes on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- vn_valid  in  1  write strobe from decoder.
- vn_idx  in  5  variable-node index 0..19.
- vn_val  in  W  soft value of node vn_idx.
- vn_ready  out  1  high when writes are accepted.
- frame_clr  in  1  synchronous abort/clear of the current frame.
- dec_valid  out  1  result available.
- dec_ready  in  1  sink accepts result.
- dec_bits  out  20  hard decisions; bit j belongs to node j.
- syndrome  out  M  H·dec_bits over GF(2); bit r belongs to check r.
- ok_n  out  1  0 when syndrome==0; valid while dec_valid=1.
- idx_err  out  1  one-cycle pulse when an out-of-range index is written.

Behaviour:
- Reset (async, rst_n=0):
  - state=COLLECT; bit store, received mask, syndrome and column counter cleared.
  - vn_ready=1, dec_valid=0, dec_bits=0, syndrome=0, ok_n=1, idx_err=0.
- Hard decision: bit = vn_val[W-1] (values 4..7 give 1; 0..3 give 0).
- Fixed H, listed per column j as the set of checks it touches:
  - 0:{0,5,9} 1:{0,2,8} 2:{3,6,9} 3:{2,4,7} 4:{1,5,9} 5:{0,7,8} 6:{1,3,6}
  - 7:{2,5,8} 8:{1,3,7} 9:{4,6,8} 10:{0,2,8} 11:{1,4,7} 12:{0,3,7}
  - 13:{0,1,5} 14:{1,2,4} 15:{2,3,7} 16:{3,4,6} 17:{4,5,7} 18:{5,6,9} 19:{6,7,8}
- COLLECT (vn_ready=1):
  - On each edge with vn_valid=1 and vn_idx<20: store the hard bit at vn_idx and set mask[vn_idx].
  - Rewriting an index overwrites the stored bit; the last write wins.
  - vn_idx>=20: write dropped; idx_err=1 for exactly the next cycle.
  - On the edge where the mask becomes all ones: go to CHECK with col=0 and syndrome=0. vn_ready drops the same cycle.
- CHECK (vn_ready=0):
  - Each edge: syndrome ^= (bit[col] ? Hcol[col] : 0), then col++.
  - After the edge that processes col=19: go to DONE.
  - Exactly 20 edges in CHECK.
- DONE:
  - dec_valid=1; dec_bits, syndrome and ok_n are held stable.
  - On an edge with dec_valid & dec_ready: return to COLLECT, clear the mask, set dec_valid=0 and vn_ready=1.
  - Stored bits are retained but invalidated by the mask clear.
- Latency: final accepted write at edge E0 → dec_valid high after edge E20. Ready held high gives a one-cycle dec_valid pulse.
- Writes while vn_ready=0 are ignored; idx_err is not raised for them.
- frame_clr=1 at any edge, in any state: mask, syndrome and col cleared, state=COLLECT, dec_valid=0. frame_clr has priority over a simultaneous write or handshake.
- Simultaneous dec_ready and vn_valid in DONE: the handshake completes; the write is ignored (vn_ready was 0 at that edge).
- Async reset mid-CHECK or mid-DONE: immediately returns to reset values; no partial result is emitted.

Test Plan:
- Write idx 0..19 in order, all vn_val=3'd2 → after 20 more edges dec_valid=1, dec_bits=20'h0, syndrome=10'h000, ok_n=0; dec_ready=1 → back to COLLECT, vn_ready=1.
- vn_val=3'd4 at idx 0, all others 3'd1 → dec_bits=20'h00001, syndrome=10'h221, ok_n=1.
- Node 0=3'd7 and node 13=3'd5, rest 3'd0, written in reverse order 19..0 → dec_bits=20'h02001, syndrome=10'h202, ok_n=1.
- idx 5 written 3'd6 then 3'd1 before the frame completes, rest 3'd0 → dec_bits=0, syndrome=0, ok_n=0. A write with idx 25 → idx_err pulses one cycle and the mask is unchanged.
- Hold dec_ready=0 for 10 cycles in DONE while driving vn_valid → outputs stable, writes ignored, dec_valid stays 1 until dec_ready=1.
- Assert frame_clr during CHECK at col=7 → dec_valid never rises; the next full frame of all 3'd0 yields syndrome=0 and ok_n=0. Pulse rst_n low in DONE → dec_valid=0 and ok_n=1 immediately.

Source files
------------

// File: rtl/ldpc_hd_collect_if.sv
// ldpc_hd_collect_if: variable-node write port and decoded-result handshake
interface ldpc_hd_collect_if #(parameter int N = 20, parameter int M = 10, parameter int W = 3);
    logic         vn_valid;
    logic [4:0]   vn_idx;
    logic [W-1:0] vn_val;
    logic         vn_ready;
    logic         frame_clr;
    logic         dec_valid;
    logic         dec_ready;
    logic [N-1:0] dec_bits;
    logic [M-1:0] syndrome;
    logic         ok_n;
    logic         idx_err;
    modport master (
        output vn_valid, vn_idx, vn_val, frame_clr, dec_ready,
        input  vn_ready, dec_valid, dec_bits, syndrome, ok_n, idx_err
    );
    modport slave (
        input  vn_valid, vn_idx, vn_val, frame_clr, dec_ready,
        output vn_ready, dec_valid, dec_bits, syndrome, ok_n, idx_err
    );
endinterface

// File: rtl/ldpc_hd_collect.sv
// ldpc_hd_collect: gathers hard decisions of a (20,10) LDPC frame and serially recomputes its syndrome
module ldpc_hd_collect #(parameter int N = 20, parameter int M = 10, parameter int W = 3) (
    input logic clk,
    input logic rst_n,
    ldpc_hd_collect_if.slave bus
);
    typedef enum logic [1:0] {COLLECT, CHECK, DONE} state_t;
    // Check-node membership of each column, bit r set when the column touches check r
    localparam logic [M-1:0] H [N] = '{
        10'h221, 10'h105, 10'h248, 10'h094, 10'h222, 10'h181, 10'h04A, 10'h124, 10'h08A, 10'h150,
        10'h105, 10'h092, 10'h089, 10'h023, 10'h016, 10'h08C, 10'h058, 10'h0B0, 10'h260, 10'h1C0
    };
    state_t state, state_nx;
    logic [N-1:0] hard, mask, wr_bit;
    logic [M-1:0] syn;
    logic [4:0] col;
    logic idx_err, wr_ok;
    always_comb begin
        wr_ok = bus.vn_valid && bus.vn_idx < 5'(N);
        wr_bit = wr_ok ? N'(1) << bus.vn_idx : '0;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= COLLECT;
        else state <= state_nx;
    end
    always_comb begin
        state_nx = state;
        if (bus.frame_clr) state_nx = COLLECT;
        else if (state == COLLECT && wr_ok && (mask | wr_bit) == '1) state_nx = CHECK;
        else if (state == CHECK && col == 5'(N - 1)) state_nx = DONE;
        else if (state == DONE && bus.dec_ready) state_nx = COLLECT;
    end
    always_comb begin
        bus.vn_ready = state == COLLECT;
        bus.dec_valid = state == DONE;
        bus.dec_bits = hard;
        bus.syndrome = syn;
        bus.ok_n = !(state == DONE && syn == '0);
        bus.idx_err = idx_err;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hard <= '0;
            mask <= '0;
            syn <= '0;
            col <= '0;
            idx_err <= 1'b0;
        end else if (bus.frame_clr) begin
            mask <= '0;
            syn <= '0;
            col <= '0;
            idx_err <= 1'b0;
        end else begin
            idx_err <= state == COLLECT && bus.vn_valid && !wr_ok;
            if (state == COLLECT) begin
                hard <= (hard & ~wr_bit) | (wr_bit & {N{bus.vn_val[W-1]}});
                mask <= mask | wr_bit;
                syn <= '0;
                col <= '0;
            end else if (state == CHECK) begin
                syn <= syn ^ (hard[col] ? H[col] : '0);
                col <= col + 5'd1;
            end else if (bus.dec_ready) begin
                mask <= '0;
            end
        end
    end
endmodule
